rv32i_control_logic: RTL and testbench
======================================

// Module: rv32i_control_logic
// PURPOSE
// - Main decoder for the single-cycle RV32I core: maps the fetched instruction plus
//   branch-comparator flags to datapath selects (PC, immediate, ALU operands, ALU op,
//   memory write, writeback).
// - Control outputs are combinational (same-cycle decode).
// - clk/rst_n hold only a sticky illegal-opcode status bit and force safe outputs in reset.
// PARAMETERS
// - none
// PORTS
// - clk           in   1   core clock, rising edge
// - rst_n         in   1   asynchronous, active-low reset
// - instr         in   32  current instruction
// - BrEq          in   1   branch comparator: rs1 == rs2
// - BrLT          in   1   branch comparator: rs1 < rs2 (signedness per BrUn)
// - PCSel         out  1   0 = PC+4, 1 = ALU result (jump/branch target)
// - ImmSel        out  3   immediate format: 0=I 1=S 2=B 3=U 4=J
// - RegWEn        out  1   register-file write enable
// - BrUn          out  1   1 = unsigned compare (BLTU/BGEU)
// - Bsel          out  1   ALU B operand: 0 = rs2, 1 = immediate
// - Asel          out  1   ALU A operand: 0 = rs1, 1 = PC
// - ALUSel        out  4   ALU op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR,
//                          6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
// - MemRW         out  1   1 = data-memory write, 0 = read/idle
// - WBSel         out  2   writeback: 0 = mem, 1 = ALU, 2 = PC+4
// - IllegalInstr  out  1   sticky flag: unsupported opcode was decoded
// BEHAVIOUR
// - Decode key: opcode = instr[6:0], funct3 = instr[14:12], funct7b5 = instr[30].
// - Default (NOP): PCSel=0, ImmSel=0, RegWEn=0, BrUn=0, Asel=0, Bsel=0, ALUSel=0,
//   MemRW=0, WBSel=1.
// - R-type 0x33: RegWEn=1, Asel=0, Bsel=0, WBSel=1.
//   - ALUSel from funct3: 000 ADD/SUB (SUB if funct7b5), 001 SLL, 010 SLT, 011 SLTU,
//     100 XOR, 101 SRL/SRA (SRA if funct7b5), 110 OR, 111 AND.
// - I-ALU 0x13: as R-type, but Bsel=1, ImmSel=I.
//   - funct3=000 is always ADD (instr[30] ignored); funct3=101 uses instr[30] for SRA.
// - Load 0x03: RegWEn=1, ImmSel=I, Bsel=1, ALUSel=ADD, WBSel=0.
// - Store 0x23: ImmSel=S, Bsel=1, ALUSel=ADD, MemRW=1, RegWEn=0.
// - Branch 0x63: ImmSel=B, Asel=1, Bsel=1, ALUSel=ADD, RegWEn=0.
//   - BrUn=1 for funct3 110/111, else 0.
//   - PCSel by funct3: BEQ BrEq, BNE !BrEq, BLT/BLTU BrLT, BGE/BGEU !BrLT.
//   - funct3 010/011: PCSel=0.
// - JAL 0x6F: PCSel=1, ImmSel=J, Asel=1, Bsel=1, ALUSel=ADD, RegWEn=1, WBSel=2.
// - JALR 0x67: PCSel=1, ImmSel=I, Asel=0, Bsel=1, ALUSel=ADD, RegWEn=1, WBSel=2.
// - LUI 0x37: ImmSel=U, Bsel=1, ALUSel=PASSB, RegWEn=1, WBSel=1.
// - AUIPC 0x17: ImmSel=U, Asel=1, Bsel=1, ALUSel=ADD, RegWEn=1, WBSel=1.
// - FENCE 0x0F / SYSTEM 0x73: NOP defaults, not illegal.
// - Any other opcode: NOP defaults; IllegalInstr set at the next rising clk.
//   - IllegalInstr stays set until reset.
// - Reset: while rst_n=0, all outputs forced to NOP defaults (RegWEn=MemRW=PCSel=0)
//   asynchronously; IllegalInstr cleared to 0 asynchronously.
// - Outputs change combinationally with instr/BrEq/BrLT; no latency, no latches.
// TESTING
// - ADD 0x003100B3 -> RegWEn=1, ALUSel=0, Asel=0, Bsel=0, WBSel=1, PCSel=0, MemRW=0.
// - SUB 0x403100B3 -> ALUSel=1.
//   ADDI 0x00510093 -> ALUSel=0, Bsel=1, ImmSel=0.
// - LW 0x00412083 -> WBSel=0, RegWEn=1, Bsel=1.
//   SW 0x00112223 -> ImmSel=1, MemRW=1, RegWEn=0.
// - BEQ 0x00208863 -> ImmSel=2, Asel=1, Bsel=1, RegWEn=0; PCSel=1 with BrEq=1,
//   PCSel=0 with BrEq=0.
//   BLTU: BrUn=1; PCSel follows BrLT.
// - JAL 0x00C000EF -> PCSel=1, ImmSel=4, Asel=1, WBSel=2.
//   JALR 0x004100E7 -> PCSel=1, Asel=0, ImmSel=0, WBSel=2.
// - LUI 0x000010B7 -> ImmSel=3, ALUSel=10, RegWEn=1.
//   AUIPC 0x00001097 -> Asel=1, ALUSel=0.
//   Illegal opcode 0x7F -> NOP outputs, IllegalInstr=1 after clk edge, cleared by rst_n=0.

Source files
------------

// File: rtl/rv32i_control_logic.sv
// Main decoder for the single-cycle RV32I core. It maps an instruction and the branch
// comparator flags to datapath selects, and keeps a sticky illegal-opcode status bit.
module rv32i_control_logic (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        BrEq,
    input  logic        BrLT,
    output logic        PCSel,
    output logic [2:0]  ImmSel,
    output logic        RegWEn,
    output logic        BrUn,
    output logic        Bsel,
    output logic        Asel,
    output logic [3:0]  ALUSel,
    output logic        MemRW,
    output logic [1:0]  WBSel,
    output logic        IllegalInstr
);

    typedef enum logic [6:0] {
        OP_R      = 7'h33,
        OP_I_ALU  = 7'h13,
        OP_LOAD   = 7'h03,
        OP_STORE  = 7'h23,
        OP_BRANCH = 7'h63,
        OP_JAL    = 7'h6F,
        OP_JALR   = 7'h67,
        OP_LUI    = 7'h37,
        OP_AUIPC  = 7'h17,
        OP_FENCE  = 7'h0F,
        OP_SYSTEM = 7'h73
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_t;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       funct7b5_s;

    assign opcode_s   = instr[6:0];
    assign funct3_s   = instr[14:12];
    assign funct7b5_s = instr[30];

    // Register/immediate fields are consumed by the datapath, not by this decoder.
    logic unused_s;
    assign unused_s = &{1'b0, instr[31], instr[29:15], instr[11:7]};

    logic [3:0] alu_rr_s;
    logic [3:0] alu_ri_s;
    logic       br_take_s;
    logic       br_unsigned_s;

    logic       pcsel_s;
    logic [2:0] immsel_s;
    logic       regwen_s;
    logic       brun_s;
    logic       bsel_s;
    logic       asel_s;
    logic [3:0] alusel_s;
    logic       memrw_s;
    logic [1:0] wbsel_s;
    logic       illegal_s;
    logic       illegal_r;

    // ALU operation for register-register ops: funct7b5 selects SUB and SRA.
    always_comb begin
        alu_rr_s = ALU_ADD;
        case (funct3_s)
            3'b000:  alu_rr_s = funct7b5_s ? ALU_SUB : ALU_ADD;
            3'b001:  alu_rr_s = ALU_SLL;
            3'b010:  alu_rr_s = ALU_SLT;
            3'b011:  alu_rr_s = ALU_SLTU;
            3'b100:  alu_rr_s = ALU_XOR;
            3'b101:  alu_rr_s = funct7b5_s ? ALU_SRA : ALU_SRL;
            3'b110:  alu_rr_s = ALU_OR;
            3'b111:  alu_rr_s = ALU_AND;
            default: alu_rr_s = ALU_ADD;
        endcase
    end

    // ALU operation for register-immediate ops: ADDI has no SUB form, bit 30 is immediate data.
    always_comb begin
        alu_ri_s = alu_rr_s;
        if (funct3_s == 3'b000) begin
            alu_ri_s = ALU_ADD;
        end else begin
            alu_ri_s = alu_rr_s;
        end
    end

    // Branch condition evaluation from the comparator flags.
    always_comb begin
        br_take_s     = 1'b0;
        br_unsigned_s = 1'b0;
        case (funct3_s)
            3'b000:  br_take_s = BrEq;
            3'b001:  br_take_s = ~BrEq;
            3'b100:  br_take_s = BrLT;
            3'b101:  br_take_s = ~BrLT;
            3'b110: begin
                br_take_s     = BrLT;
                br_unsigned_s = 1'b1;
            end
            3'b111: begin
                br_take_s     = ~BrLT;
                br_unsigned_s = 1'b1;
            end
            default: begin
                br_take_s     = 1'b0;
                br_unsigned_s = 1'b0;
            end
        endcase
    end

    // Main opcode decode; anything unrecognised falls back to NOP and flags illegal.
    always_comb begin
        pcsel_s   = 1'b0;
        immsel_s  = IMM_I;
        regwen_s  = 1'b0;
        brun_s    = 1'b0;
        bsel_s    = 1'b0;
        asel_s    = 1'b0;
        alusel_s  = ALU_ADD;
        memrw_s   = 1'b0;
        wbsel_s   = WB_ALU;
        illegal_s = 1'b0;
        case (opcode_s)
            OP_R: begin
                regwen_s = 1'b1;
                alusel_s = alu_rr_s;
            end
            OP_I_ALU: begin
                regwen_s = 1'b1;
                bsel_s   = 1'b1;
                alusel_s = alu_ri_s;
            end
            OP_LOAD: begin
                regwen_s = 1'b1;
                bsel_s   = 1'b1;
                wbsel_s  = WB_MEM;
            end
            OP_STORE: begin
                immsel_s = IMM_S;
                bsel_s   = 1'b1;
                memrw_s  = 1'b1;
            end
            OP_BRANCH: begin
                immsel_s = IMM_B;
                asel_s   = 1'b1;
                bsel_s   = 1'b1;
                brun_s   = br_unsigned_s;
                pcsel_s  = br_take_s;
            end
            OP_JAL: begin
                pcsel_s  = 1'b1;
                immsel_s = IMM_J;
                asel_s   = 1'b1;
                bsel_s   = 1'b1;
                regwen_s = 1'b1;
                wbsel_s  = WB_PC4;
            end
            OP_JALR: begin
                pcsel_s  = 1'b1;
                bsel_s   = 1'b1;
                regwen_s = 1'b1;
                wbsel_s  = WB_PC4;
            end
            OP_LUI: begin
                immsel_s = IMM_U;
                bsel_s   = 1'b1;
                alusel_s = ALU_PASSB;
                regwen_s = 1'b1;
            end
            OP_AUIPC: begin
                immsel_s = IMM_U;
                asel_s   = 1'b1;
                bsel_s   = 1'b1;
                regwen_s = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
                illegal_s = 1'b0;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Output stage: hold every select at its NOP value while reset is asserted.
    always_comb begin
        PCSel  = 1'b0;
        ImmSel = IMM_I;
        RegWEn = 1'b0;
        BrUn   = 1'b0;
        Bsel   = 1'b0;
        Asel   = 1'b0;
        ALUSel = ALU_ADD;
        MemRW  = 1'b0;
        WBSel  = WB_ALU;
        if (rst_n) begin
            PCSel  = pcsel_s;
            ImmSel = immsel_s;
            RegWEn = regwen_s;
            BrUn   = brun_s;
            Bsel   = bsel_s;
            Asel   = asel_s;
            ALUSel = alusel_s;
            MemRW  = memrw_s;
            WBSel  = wbsel_s;
        end else begin
            PCSel  = 1'b0;
            RegWEn = 1'b0;
            MemRW  = 1'b0;
        end
    end

    // Sticky illegal-opcode status, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (illegal_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign IllegalInstr = illegal_r;

endmodule

// File: tb/tb_rv32i_control_logic.sv
// Directed-vector bench for rv32i_control_logic with hand-computed control words.
module tb_rv32i_control_logic;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        BrEq;
    logic        BrLT;
    logic        PCSel;
    logic [2:0]  ImmSel;
    logic        RegWEn;
    logic        BrUn;
    logic        Bsel;
    logic        Asel;
    logic [3:0]  ALUSel;
    logic        MemRW;
    logic [1:0]  WBSel;
    logic        IllegalInstr;

    int n_vec;
    int n_err;

    rv32i_control_logic dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .BrEq         (BrEq),
        .BrLT         (BrLT),
        .PCSel        (PCSel),
        .ImmSel       (ImmSel),
        .RegWEn       (RegWEn),
        .BrUn         (BrUn),
        .Bsel         (Bsel),
        .Asel         (Asel),
        .ALUSel       (ALUSel),
        .MemRW        (MemRW),
        .WBSel        (WBSel),
        .IllegalInstr (IllegalInstr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout: {PCSel, ImmSel, RegWEn, BrUn, Bsel, Asel, ALUSel, MemRW, WBSel}
    function automatic logic [14:0] ctl(input logic pc, input logic [2:0] imm, input logic rw,
                                        input logic un, input logic b, input logic a,
                                        input logic [3:0] alu, input logic mem, input logic [1:0] wb);
        return {pc, imm, rw, un, b, a, alu, mem, wb};
    endfunction

    function automatic logic [14:0] observed();
        return {PCSel, ImmSel, RegWEn, BrUn, Bsel, Asel, ALUSel, MemRW, WBSel};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [31:0] ins, input logic eq,
                         input logic lt, input logic [14:0] exp);
        @(negedge clk);
        instr = ins;
        BrEq  = eq;
        BrLT  = lt;
        #1;
        check_val(tag, {17'd0, observed()}, {17'd0, exp});
    endtask

    localparam logic [14:0] NOP = 15'b0_000_0_0_0_0_0000_0_01;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        instr = 32'h003100B3;
        BrEq  = 1'b1;
        BrLT  = 1'b1;
        #12;
        check_val("reset_outputs", {17'd0, observed()}, {17'd0, NOP});
        check_val("reset_illegal", {31'd0, IllegalInstr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type ALU ops
        apply("add",  32'h003100B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd1));
        apply("sub",  32'h403100B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 2'd1));
        apply("sll",  32'h003110B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 2'd1));
        apply("slt",  32'h003120B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 2'd1));
        apply("sltu", 32'h003130B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 2'd1));
        apply("xor",  32'h003140B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 2'd1));
        apply("srl",  32'h003150B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 2'd1));
        apply("sra",  32'h403150B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 2'd1));
        apply("or",   32'h003160B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 2'd1));
        apply("and",  32'h003170B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 2'd1));

        // I-type ALU ops, including bit 30 set on ADDI
        apply("addi",     32'h00510093, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd1));
        apply("addi_b30", 32'h40510093, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd1));
        apply("srli",     32'h00515093, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, 2'd1));
        apply("srai",     32'h40515093, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 2'd1));

        // Memory
        apply("lw", 32'h00412083, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0));
        apply("sw", 32'h00112223, 1'b0, 1'b0, ctl(1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 2'd1));

        // Branches, taken and not taken
        apply("beq_t",  32'h00208863, 1'b1, 1'b0, ctl(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("beq_n",  32'h00208863, 1'b0, 1'b1, ctl(1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("bne_t",  32'h00209863, 1'b0, 1'b0, ctl(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("bne_n",  32'h00209863, 1'b1, 1'b0, ctl(1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("blt_t",  32'h0020C863, 1'b0, 1'b1, ctl(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("blt_n",  32'h0020C863, 1'b1, 1'b0, ctl(1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("bge_t",  32'h0020D863, 1'b0, 1'b0, ctl(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("bge_n",  32'h0020D863, 1'b0, 1'b1, ctl(1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("bltu_t", 32'h0020E863, 1'b0, 1'b1, ctl(1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("bltu_n", 32'h0020E863, 1'b0, 1'b0, ctl(1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("bgeu_t", 32'h0020F863, 1'b1, 1'b0, ctl(1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("bgeu_n", 32'h0020F863, 1'b1, 1'b1, ctl(1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("br_f2",  32'h0020A863, 1'b1, 1'b1, ctl(1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));
        apply("br_f3",  32'h0020B863, 1'b0, 1'b0, ctl(1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));

        // Jumps and upper immediates
        apply("jal",   32'h00C000EF, 1'b0, 1'b0, ctl(1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd2));
        apply("jalr",  32'h004100E7, 1'b0, 1'b0, ctl(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd2));
        apply("lui",   32'h000010B7, 1'b0, 1'b0, ctl(1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 2'd1));
        apply("auipc", 32'h00001097, 1'b0, 1'b0, ctl(1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd1));

        // FENCE / SYSTEM decode as NOP without flagging
        apply("fence",  32'h0000000F, 1'b1, 1'b1, NOP);
        apply("system", 32'h00000073, 1'b1, 1'b1, NOP);
        @(posedge clk);
        #1;
        check_val("legal_no_flag", {31'd0, IllegalInstr}, 32'd0);

        // Illegal opcode: NOP immediately, flag after the next rising edge
        apply("illegal_nop", 32'h0000007F, 1'b1, 1'b1, NOP);
        check_val("illegal_pre_edge", {31'd0, IllegalInstr}, 32'd0);
        @(posedge clk);
        #1;
        check_val("illegal_set", {31'd0, IllegalInstr}, 32'd1);
        apply("add_after_ill", 32'h003100B3, 1'b0, 1'b0, ctl(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd1));
        @(posedge clk);
        #1;
        check_val("illegal_sticky", {31'd0, IllegalInstr}, 32'd1);

        // Asynchronous reset mid-cycle: flag clears and outputs go to NOP without a clock edge
        apply("jal_pre_rst", 32'h00C000EF, 1'b0, 1'b0, ctl(1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd2));
        rst_n = 1'b0;
        #1;
        check_val("async_rst_outputs", {17'd0, observed()}, {17'd0, NOP});
        check_val("async_rst_illegal", {31'd0, IllegalInstr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("lui_post_rst", 32'h000010B7, 1'b0, 1'b0, ctl(1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, 2'd1));
        check_val("post_rst_illegal", {31'd0, IllegalInstr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
